// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples the rows,
// debounces whole scans and reports each newly accepted key with a one-cycle strobe.
module keypad_scan #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEBOUNCE = 5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key,
    output logic       valid,
    output logic       pressed
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    // Scan codes are {found, hex}; NONE has found cleared.
    localparam logic [4:0] CODE_NONE = 5'b0_0000;

    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_t;

    logic [DW-1:0] dwell_q;
    logic [1:0]    c_q;
    logic [3:0]    col_q;
    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [4:0]    acc_q;
    logic [4:0]    prev_q;
    logic [SW-1:0] stable_q;
    state_t        state_q;
    logic [3:0]    key_q;
    logic          valid_q;
    logic          pressed_q;

    logic          sample_now;
    logic          scan_end;
    logic [3:0]    row_low;
    logic [1:0]    first_row;
    logic [4:0]    col_code;
    logic [4:0]    scan_code_d;
    logic [SW-1:0] stable_d;
    logic          accept;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        k = 4'h0;
        case ({c, r})
            4'h0: k = 4'h1;
            4'h1: k = 4'h4;
            4'h2: k = 4'h7;
            4'h3: k = 4'h0;
            4'h4: k = 4'h2;
            4'h5: k = 4'h5;
            4'h6: k = 4'h8;
            4'h7: k = 4'hF;
            4'h8: k = 4'h3;
            4'h9: k = 4'h6;
            4'hA: k = 4'h9;
            4'hB: k = 4'hE;
            4'hC: k = 4'hA;
            4'hD: k = 4'hB;
            4'hE: k = 4'hC;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Per-column sample decode, scan accumulation and debounce count.
    always_comb begin
        sample_now = (dwell_q == DWELL_LAST);
        scan_end   = sample_now && (c_q == 2'd3);
        row_low    = ~row_sync_q;
        first_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) first_row = 2'(r);
        end
        col_code    = (|row_low) ? {1'b1, key_map(c_q, first_row)} : CODE_NONE;
        // An earlier column's hit in this scan takes priority.
        scan_code_d = ((c_q != 2'd0) && acc_q[4]) ? acc_q : col_code;
        if (scan_code_d == prev_q) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
        end else begin
            stable_d = SW'(1);
        end
        accept = scan_end && (stable_d == STABLE_MAX);
    end

    // Column sequencing, row synchronizer and scan history.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q    <= '0;
            c_q        <= 2'd0;
            col_q      <= 4'b1110;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            acc_q      <= CODE_NONE;
            prev_q     <= CODE_NONE;
            stable_q   <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            if (sample_now) begin
                dwell_q <= '0;
                c_q     <= c_q + 2'd1;
                col_q   <= ~(4'b0001 << (c_q + 2'd1));
                acc_q   <= scan_code_d;
                if (scan_end) begin
                    prev_q   <= scan_code_d;
                    stable_q <= stable_d;
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    // Acceptance FSM; the strobe fires only when the held key actually changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key_q     <= 4'h0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        if (scan_code_d[4]) begin
                            state_q   <= ST_HELD;
                            key_q     <= scan_code_d[3:0];
                            valid_q   <= 1'b1;
                            pressed_q <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!scan_code_d[4]) begin
                            state_q   <= ST_IDLE;
                            pressed_q <= 1'b0;
                        end else if (scan_code_d[3:0] != key_q) begin
                            key_q   <= scan_code_d[3:0];
                            valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign col     = col_q;
    assign key     = key_q;
    assign valid   = valid_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed plus randomized bench for keypad_scan with a keypad model driving rows
// from the column drive and a scan-level reference of the debounce/acceptance rules.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned SCAN_LEN = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        valid;
    logic        pressed;

    logic [15:0] held;   // bit c*4+r set when the key at column c, row r is pressed

    int tests;
    int fails;

    logic [4:0]  hist[$];
    logic [3:0]  m_key;
    logic        m_pressed;
    logic        m_valid;

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .col    (col),
        .row    (row),
        .key    (key),
        .valid  (valid),
        .pressed(pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col[c] == 1'b0 && held[c*4+r]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] hex_of(input int idx);
        string layout;
        byte   ch;
        layout = "1470258F369EABCD";
        ch = layout[idx];
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    // First pressed key in column-major, row-minor order; 5'h00 means none.
    function automatic logic [4:0] code_of(input logic [15:0] keys);
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) return {1'b1, hex_of(i)};
        end
        return 5'h00;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_key     = 4'h0;
        m_pressed = 1'b0;
        m_valid   = 1'b0;
    endtask

    // A code is accepted once the last DEBOUNCE scans all agree on it.
    task automatic model_scan_end(input logic [4:0] code);
        bit same;
        m_valid = 1'b0;
        hist.push_back(code);
        if (hist.size() > DEBOUNCE) hist.delete(0);
        if (hist.size() == DEBOUNCE) begin
            same = 1'b1;
            foreach (hist[j]) if (hist[j] != hist[0]) same = 1'b0;
            if (same) begin
                if (code[4]) begin
                    if (!m_pressed || m_key != code[3:0]) begin
                        m_key     = code[3:0];
                        m_pressed = 1'b1;
                        m_valid   = 1'b1;
                    end
                end else begin
                    m_pressed = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_col(input int phase);
        logic [3:0] e;
        e = 4'hF;
        e[phase / SCAN_DIV] = 1'b0;
        return e;
    endfunction

    // Runs n cycles of the current scan from phase 0 without reaching its end.
    task automatic run_cycles(input logic [15:0] keys, input int n);
        held = keys;
        for (int i = 0; i < n; i++) begin
            check("col", 16'(col), 16'(exp_col(i)));
            @(posedge clk);
            #1;
            check("valid_mid", 16'(valid), 16'h0);
        end
    endtask

    task automatic run_scan(input logic [15:0] keys);
        held = keys;
        for (int i = 0; i < SCAN_LEN; i++) begin
            check("col", 16'(col), 16'(exp_col(i)));
            @(posedge clk);
            #1;
            if (i < SCAN_LEN - 1) check("valid_mid", 16'(valid), 16'h0);
        end
        model_scan_end(code_of(keys));
        check("valid_end", 16'(valid), 16'(m_valid));
        check("key", 16'(key), 16'(m_key));
        check("pressed", 16'(pressed), 16'(m_pressed));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_col", 16'(col), 16'h000E);
        check("rst_key", 16'(key), 16'h0);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_pressed", 16'(pressed), 16'h0);
    endtask

    initial begin
        logic [15:0] k;
        int          mode;
        int          len;
        tests = 0;
        fails = 0;
        held  = 16'h0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Free-run with no keys.
        repeat (2) run_scan(16'h0);

        // Key 5 toggled every scan never debounces.
        repeat (2) begin
            run_scan(16'h0020);
            run_scan(16'h0000);
        end
        check("toggle_pressed", 16'(pressed), 16'h0);

        // Hold key 5 from a scan start, then 10 more scans.
        repeat (13) run_scan(16'h0020);
        check("hold5_key", 16'(key), 16'h5);
        check("hold5_pressed", 16'(pressed), 16'h1);

        // Release: pressed falls, key keeps 5.
        repeat (4) run_scan(16'h0000);
        check("rel5_key", 16'(key), 16'h5);
        check("rel5_pressed", 16'(pressed), 16'h0);

        // 1 and D together: 1 wins; then D alone.
        repeat (4) run_scan(16'h8001);
        check("multi_key", 16'(key), 16'h1);
        repeat (4) run_scan(16'h8000);
        check("d_key", 16'(key), 16'hD);
        check("d_pressed", 16'(pressed), 16'h1);
        repeat (4) run_scan(16'h0000);

        // Reset mid-scan with key 9 partially debounced.
        repeat (2) run_scan(16'h0400);
        run_cycles(16'h0400, 13);
        do_reset();
        repeat (2) run_scan(16'h0400);
        check("rst9_early", 16'(pressed), 16'h0);
        run_scan(16'h0400);
        check("rst9_key", 16'(key), 16'h9);
        check("rst9_pressed", 16'(pressed), 16'h1);

        // Randomized key patterns held for random numbers of scans.
        k = 16'h0400;
        for (int seg = 0; seg < 14; seg++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: k = 16'h0;
                1: begin
                    k = 16'h0;
                    k[$urandom_range(0, 15)] = 1'b1;
                end
                2: begin
                    k = 16'h0;
                    k[$urandom_range(0, 15)] = 1'b1;
                    k[$urandom_range(0, 15)] = 1'b1;
                end
                default: ;
            endcase
            len = int'($urandom_range(1, 5));
            repeat (len) run_scan(k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
